nios2_debug_jtag_master: RTL

NIOS2_DEBUG_JTAG_MASTER -- requirements
Module: nios2_debug_jtag_master

---
 rtl/nios2_debug_pkg.sv | 27 ++
 rtl/nios2_debug_tck_gen.sv | 55 +++++
 rtl/nios2_debug_jtag_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nios2_debug_pkg.sv
// rtl/nios2_debug_pkg.sv - shared types and constants for the Nios II virtual-JTAG debug master
package nios2_debug_pkg;

  localparam int SR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH         = 2;

  // Virtual IR codes understood by the Nios II debug slave.
  localparam logic [IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [IR_WIDTH-1:0] IR_TRACE     = 2'd1;
  localparam logic [IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // States that run the TCK divider (whole TCK periods).
  function automatic logic is_tck_state(input state_e s);
    return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) || (s == ST_UDR);
  endfunction

endpackage

// File: rtl/nios2_debug_tck_gen.sv
// rtl/nios2_debug_tck_gen.sv - divides clk into the virtual-JTAG TCK and its period enables
// Ports:
//   clk_i, rst_i   system clock, asynchronous active-high reset
//   run_i          divider runs while high; held at tck=0, phase 0 while low
//   tck_o          registered TCK: low for TCK_DIV cycles, then high for TCK_DIV cycles
//   rise_en_o      high in the cycle whose closing clk edge raises tck_o
//   period_end_o   high in the last cycle of a TCK period
module nios2_debug_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tck_o,
  output logic rise_en_o,
  output logic period_end_o
);

  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       tck_q, tck_d;
  logic       half_end;

  assign half_end = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    tck_d = tck_q;
    if (!run_i) begin
      div_d = '0;
      tck_d = 1'b0;
    end else if (half_end) begin
      div_d = '0;
      tck_d = ~tck_q;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o        = tck_q;
  assign rise_en_o    = run_i & ~tck_q & half_end;
  assign period_end_o = run_i &  tck_q & half_end;

endmodule

// File: rtl/nios2_debug_jtag_master.sv
// rtl/nios2_debug_jtag_master.sv - command-driven virtual-JTAG master for the Nios II debug slave
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_ir + cmd_data latched on acceptance
//   rsp_valid/rsp_ready        response handshake; rsp_data holds the captured register
//   vji_tck/tdi/rti/uir/cdr/sdr/udr/ir_in   registered virtual-JTAG drive toward the slave
//   vji_tdo                    serial data back from the slave
//   busy                       high whenever the sequencer is not idle
module nios2_debug_jtag_master
  import nios2_debug_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int SR_WIDTH = SR_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  output logic                busy
);

  localparam int CW = $clog2(SR_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SR_WIDTH - 1);

  state_e                state_q, state_d;
  logic [SR_WIDTH-1:0]   sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic                  rsp_ack_q, rsp_ack_d;
  logic                  tdi_q, tdi_d;
  logic                  rti_q, rti_d;
  logic                  uir_q, uir_d;
  logic                  cdr_q, cdr_d;
  logic                  sdr_q, sdr_d;
  logic                  udr_q, udr_d;

  logic tck_run, rise_en, period_end, cmd_fire, last_shift;

  assign tck_run    = is_tck_state(state_q);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign last_shift = (cnt_q == CNT_LAST);

  nios2_debug_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk_i        (clk),
    .rst_i        (reset),
    .run_i        (tck_run),
    .tck_o        (vji_tck),
    .rise_en_o    (rise_en),
    .period_end_o (period_end)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ir_q      <= '0;
      rsp_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      rsp_ack_q <= rsp_ack_d;
    end
  end

  // Next state. RESP leaves one edge after the response handshake edge,
  // so the handshake cycle itself still reads as busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid)                 state_d = ST_UIR;
      ST_UIR:  if (period_end)                state_d = ST_CDR;
      ST_CDR:  if (period_end)                state_d = ST_SDR;
      ST_SDR:  if (period_end && last_shift)  state_d = ST_UDR;
      ST_UDR:  if (period_end)                state_d = ST_RESP;
      ST_RESP: if (rsp_ack_q)                 state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ir_d      = ir_q;
    rsp_ack_d = 1'b0;
    if (cmd_fire) begin
      sr_d = cmd_data;
      ir_d = cmd_ir;
    end
    if (state_q == ST_SDR && rise_en) begin
      sr_d = {vji_tdo, sr_q[SR_WIDTH-1:1]};
    end
    if (state_q == ST_SDR && period_end) begin
      cnt_d = last_shift ? '0 : cnt_q + 1'b1;
    end
    if (state_q == ST_RESP && !rsp_ack_q && rsp_ready) begin
      rsp_ack_d = 1'b1;
    end
  end

  // Registered strobe outputs are computed from the next state so they line
  // up with the state they describe. tdi is loaded at each SDR period start
  // and held through the mid-period shift.
  always_comb begin
    rti_d = (state_d == ST_IDLE);
    uir_d = (state_d == ST_UIR);
    cdr_d = (state_d == ST_CDR);
    sdr_d = (state_d == ST_SDR);
    udr_d = (state_d == ST_UDR);
    tdi_d = 1'b0;
    if (state_d == ST_SDR) begin
      tdi_d = period_end ? sr_q[0] : tdi_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rti_q <= 1'b1;
      uir_q <= 1'b0;
      cdr_q <= 1'b0;
      sdr_q <= 1'b0;
      udr_q <= 1'b0;
      tdi_q <= 1'b0;
    end else begin
      rti_q <= rti_d;
      uir_q <= uir_d;
      cdr_q <= cdr_d;
      sdr_q <= sdr_d;
      udr_q <= udr_d;
      tdi_q <= tdi_d;
    end
  end

  assign vji_rti   = rti_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP) && !rsp_ack_q;
  assign rsp_data  = sr_q;

endmodule
